lenet_layer_sequencer: RTL

- Top-level per-image scheduler for the LeNet accelerator. Sequences input load, then convolution (conv1+conv2), then fully-connected, over a batch of images.
- Issues one-cycle start pulses to the convolution engine and the FC engine, and waits on their done pulses.
- Applies a per-phase watchdog and exposes cycle-count performance registers.
- Sits between the host/testbench control interface and the conv/fc engines.

---
 rtl/lenet_pkg.sv | 20 ++
 rtl/phase_timer.sv | 41 ++++
 rtl/lenet_layer_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared types for the LeNet layer sequencer: FSM state encoding and error-phase codes.
package lenet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV,
        ST_FC,
        ST_NEXT,
        ST_ERR
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_LOAD  = 2'd0,
        ERR_CONV  = 2'd1,
        ERR_FC    = 2'd2,
        ERR_PROTO = 2'd3
    } err_phase_e;

endpackage

// File: rtl/phase_timer.sv
// Saturating phase counter with clear and enable; hit_o flags that the count
// reaches LIMIT on the coming clock edge (or already sits there).
module phase_timer #(
    parameter int WIDTH = 20,
    parameter int LIMIT = 500000
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             hit_o
);

    localparam logic [WIDTH-1:0] LIM    = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIM)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // hit_o depends only on registered state so the sequencer can use it in its next-state logic.
    assign hit_o   = en_i && (count_q >= LIM_M1);
    assign count_o = count_q;

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Per-image scheduler for the LeNet accelerator: load -> conv -> fc over a batch,
// with a per-phase watchdog and last-image cycle-count registers.
module lenet_layer_sequencer
    import lenet_pkg::*;
#(
    parameter int IMG_CNT_WIDTH  = 8,
    parameter int CYC_WIDTH      = 20,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                     clk,
    input  logic                     srstn,
    input  logic                     start,
    input  logic [IMG_CNT_WIDTH-1:0] num_images,
    input  logic                     abort,
    output logic                     load_req,
    input  logic                     load_done,
    output logic                     conv_start,
    input  logic                     conv1_done,
    input  logic                     conv_done,
    output logic                     fc_start,
    input  logic                     fc_done,
    output logic                     busy,
    output logic [IMG_CNT_WIDTH-1:0] img_idx,
    output logic                     img_done,
    output logic                     batch_done,
    output logic                     error,
    output logic [1:0]               err_phase,
    output logic [CYC_WIDTH-1:0]     conv1_cycles,
    output logic [CYC_WIDTH-1:0]     conv_cycles,
    output logic [CYC_WIDTH-1:0]     fc_cycles
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (1 << CYC_WIDTH))) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1 .. 2**CYC_WIDTH-1");
    end

    seq_state_e               state_q, state_d;
    logic [IMG_CNT_WIDTH-1:0] imgs_q, imgs_d;
    logic [IMG_CNT_WIDTH-1:0] idx_q, idx_d;
    logic                     seen_q, seen_d;
    logic                     load_req_q, load_req_d;
    logic                     conv_start_q, conv_start_d;
    logic                     fc_start_q, fc_start_d;
    logic                     busy_q, busy_d;
    logic                     img_done_q, img_done_d;
    logic                     batch_done_q, batch_done_d;
    logic                     error_q, error_d;
    logic [1:0]               err_phase_q, err_phase_d;
    logic [CYC_WIDTH-1:0]     conv1_cyc_q, conv1_cyc_d;
    logic [CYC_WIDTH-1:0]     conv_cyc_q, conv_cyc_d;
    logic [CYC_WIDTH-1:0]     fc_cyc_q, fc_cyc_d;

    logic                     tmr_clr, tmr_en, tmr_hit;
    logic [CYC_WIDTH-1:0]     tmr_cnt;

    // One timer serves as both watchdog and perf counter; it restarts on every state change.
    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = (state_q == ST_LOAD) || (state_q == ST_CONV) || (state_q == ST_FC);

    phase_timer #(
        .WIDTH (CYC_WIDTH),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .srstn   (srstn),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .count_o (tmr_cnt),
        .hit_o   (tmr_hit)
    );

    always_comb begin
        state_d      = state_q;
        imgs_d       = imgs_q;
        idx_d        = idx_q;
        seen_d       = seen_q;
        conv_start_d = 1'b0;
        fc_start_d   = 1'b0;
        img_done_d   = 1'b0;
        batch_done_d = 1'b0;
        error_d      = error_q;
        err_phase_d  = err_phase_q;
        conv1_cyc_d  = conv1_cyc_q;
        conv_cyc_d   = conv_cyc_q;
        fc_cyc_d     = fc_cyc_q;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (num_images == '0) begin
                            batch_done_d = 1'b1;
                        end else begin
                            imgs_d      = num_images;
                            idx_d       = '0;
                            error_d     = 1'b0;
                            err_phase_d = ERR_LOAD;
                            state_d     = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (conv_done || fc_done) begin
                        error_d     = 1'b1;
                        err_phase_d = ERR_PROTO;
                        state_d     = ST_ERR;
                    end else if (load_done) begin
                        conv_start_d = 1'b1;
                        seen_d       = 1'b0;
                        state_d      = ST_CONV;
                    end else if (tmr_hit) begin
                        error_d     = 1'b1;
                        err_phase_d = ERR_LOAD;
                        state_d     = ST_ERR;
                    end
                end
                ST_CONV: begin
                    if (conv1_done) begin
                        conv1_cyc_d = tmr_cnt;
                        seen_d      = 1'b1;
                    end
                    if (conv_done) begin
                        if (seen_q || conv1_done) begin
                            conv_cyc_d = tmr_cnt;
                            fc_start_d = 1'b1;
                            state_d    = ST_FC;
                        end else begin
                            error_d     = 1'b1;
                            err_phase_d = ERR_PROTO;
                            state_d     = ST_ERR;
                        end
                    end else if (tmr_hit) begin
                        error_d     = 1'b1;
                        err_phase_d = ERR_CONV;
                        state_d     = ST_ERR;
                    end
                end
                ST_FC: begin
                    if (fc_done) begin
                        fc_cyc_d   = tmr_cnt;
                        img_done_d = 1'b1;
                        state_d    = ST_NEXT;
                    end else if (tmr_hit) begin
                        error_d     = 1'b1;
                        err_phase_d = ERR_FC;
                        state_d     = ST_ERR;
                    end
                end
                ST_NEXT: begin
                    if (idx_q == (imgs_q - IMG_CNT_WIDTH'(1))) begin
                        batch_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IMG_CNT_WIDTH'(1);
                        state_d = ST_LOAD;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        load_req_d = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q      <= ST_IDLE;
            imgs_q       <= '0;
            idx_q        <= '0;
            seen_q       <= 1'b0;
            load_req_q   <= 1'b0;
            conv_start_q <= 1'b0;
            fc_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            img_done_q   <= 1'b0;
            batch_done_q <= 1'b0;
            error_q      <= 1'b0;
            err_phase_q  <= 2'd0;
            conv1_cyc_q  <= '0;
            conv_cyc_q   <= '0;
            fc_cyc_q     <= '0;
        end else begin
            state_q      <= state_d;
            imgs_q       <= imgs_d;
            idx_q        <= idx_d;
            seen_q       <= seen_d;
            load_req_q   <= load_req_d;
            conv_start_q <= conv_start_d;
            fc_start_q   <= fc_start_d;
            busy_q       <= busy_d;
            img_done_q   <= img_done_d;
            batch_done_q <= batch_done_d;
            error_q      <= error_d;
            err_phase_q  <= err_phase_d;
            conv1_cyc_q  <= conv1_cyc_d;
            conv_cyc_q   <= conv_cyc_d;
            fc_cyc_q     <= fc_cyc_d;
        end
    end

    assign load_req     = load_req_q;
    assign conv_start   = conv_start_q;
    assign fc_start     = fc_start_q;
    assign busy         = busy_q;
    assign img_idx      = idx_q;
    assign img_done     = img_done_q;
    assign batch_done   = batch_done_q;
    assign error        = error_q;
    assign err_phase    = err_phase_q;
    assign conv1_cycles = conv1_cyc_q;
    assign conv_cycles  = conv_cyc_q;
    assign fc_cycles    = fc_cyc_q;

endmodule
